mem_write_arbiter: RTL and testbench
====================================

Name: mem_write_arbiter

Overview:
Shares the single memory write port (wen/waddr/wdata) between CPU stores and an internal block-fill engine. The fill engine writes one constant value to a contiguous address range, used for framebuffer clears, tilemap init and RAM zeroing. CPU stores have priority. A starvation counter guarantees fill progress by stalling the CPU for one cycle after a configurable run of CPU wins. The block sits between the CPU store stage and the memory write port.

Parameters:
STARVE_LIMIT, 4, consecutive CPU-won cycles allowed while a fill is pending before the fill takes one slot; 0 = CPU always wins (no stall ever)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cpu_wen  input  1  CPU store request
cpu_waddr  input  16  CPU store address
cpu_wdata  input  16  CPU store data
cpu_stall  output  1  CPU store not accepted this cycle; CPU holds and re-presents it
fill_start  input  1  start a fill (sampled in IDLE only)
fill_base  input  16  first fill address
fill_count  input  16  number of words to write
fill_value  input  16  word written to each address
fill_busy  output  1  fill engine in FILL state
fill_done  output  1  one-cycle pulse on fill completion
mem_wen  output  1  to memory write enable
mem_waddr  output  16  to memory write address
mem_wdata  output  16  to memory write data

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high.
- On reset: state=IDLE; fill address, remaining and value registers = 0; starve_cnt=0.
- While rst is high, all outputs are 0: mem_wen, mem_waddr, mem_wdata, cpu_stall, fill_busy, fill_done.
- The mem_* and cpu_stall outputs are combinational from the registered state and the cpu_* inputs. A CPU store has zero added latency and reaches memory in the same cycle it is presented.
- FSM states: IDLE, FILL, DONE.
- IDLE, fill_start=1:
  - Latch fill_base into addr, fill_count into remaining, fill_value into value.
  - If fill_count=0, go to DONE (no writes). Otherwise go to FILL.
- fill_start in FILL or DONE is ignored. No queuing.
- FILL, grant rules evaluated each cycle:
  - cpu_wen=0: fill granted, starve_cnt<=0.
  - cpu_wen=1 and (STARVE_LIMIT=0 or starve_cnt<STARVE_LIMIT): CPU granted, cpu_stall=0, starve_cnt<=starve_cnt+1 (not incremented when STARVE_LIMIT=0).
  - cpu_wen=1 and starve_cnt=STARVE_LIMIT>0: fill granted, cpu_stall=1, starve_cnt<=0.
- Fill grant actions:
  - mem_wen=1, mem_waddr=addr, mem_wdata=value.
  - addr<=addr+1, 16-bit wrap: 0xFFFF goes to 0x0000.
  - remaining<=remaining-1.
  - When remaining is 1 at the time of the grant, go to DONE.
- CPU grant: mem_wen=1, mem_waddr=cpu_waddr, mem_wdata=cpu_wdata. The fill registers hold.
- IDLE and DONE: CPU passes straight through, cpu_stall=0, starve_cnt=0.
- DONE: fill_done=1 for exactly one cycle, then IDLE. A fill_start in DONE is ignored; a new fill can start from the following IDLE cycle.
- fill_busy=1 only in FILL.
- cpu_stall is only ever asserted in FILL, together with cpu_wen=1. It never lasts two consecutive cycles, because starve_cnt resets on the stall cycle.
- The fill address range is not checked. Writes into the IO range (0xF000 and up) go out as-is, and the memory applies its own decode.
- Reset mid-fill: the fill is abandoned, no fill_done pulse is produced, and the engine returns to IDLE.

Test Plan:
1. Fill with no CPU traffic: base=0xE000, count=4, value=0x0041 → mem writes to E000,E001,E002,E003 on 4 consecutive cycles, fill_busy high for those 4 cycles, fill_done pulse on cycle 5.
2. Zero count: fill_start with count=0 → no mem_wen; fill_done pulses on the next cycle; fill_busy never asserts.
3. Starvation (STARVE_LIMIT=4): cpu_wen held high throughout a fill of count=2 →
   - CPU granted 4 cycles, fill 1 cycle with cpu_stall=1, then CPU 4 cycles, fill 1 cycle.
   - fill_done follows the second fill write.
   - CPU data is never lost: each stalled store appears on a later cycle.
4. Address wrap: base=0xFFFE, count=3 → writes to FFFE, FFFF, 0000.
5. Interleave and ignore: CPU store 0x1234→0x0100 on alternate cycles during a fill of count=3 →
   - CPU writes appear unchanged, with cpu_stall never asserted.
   - The fill completes in 3 of the free cycles.
   - A second fill_start issued mid-fill is ignored.
6. Reset mid-fill: assert rst during FILL with remaining=5 →
   - mem_wen=0 immediately, asynchronously.
   - After release: IDLE, fill_busy=0, no fill_done pulse.
   - A new fill starts normally.

Source files
------------

// File: rtl/mem_write_arbiter.sv
// Memory write-port arbiter: CPU stores pass straight through, a block-fill engine
// uses free slots and, after STARVE_LIMIT consecutive CPU wins, steals one slot.
module mem_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_waddr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        fill_start,
  input  logic [15:0] fill_base,
  input  logic [15:0] fill_count,
  input  logic [15:0] fill_value,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        mem_wen,
  output logic [15:0] mem_waddr,
  output logic [15:0] mem_wdata
);

  localparam int unsigned CntW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);
  localparam bit HasLimit = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_t;

  state_t          r_state;
  logic [15:0]     r_addr;
  logic [15:0]     r_remaining;
  logic [15:0]     r_value;
  logic [CntW-1:0] r_starve_cnt;

  logic w_in_fill;
  logic w_starved;
  logic w_fill_grant;

  always_comb begin
    w_in_fill    = (r_state == StFill);
    w_starved    = HasLimit && (r_starve_cnt >= Limit);
    w_fill_grant = w_in_fill && (!cpu_wen || w_starved);
  end

  // Outputs are forced low while rst is asserted, independent of the cpu_* inputs.
  always_comb begin
    mem_wen   = 1'b0;
    mem_waddr = 16'h0000;
    mem_wdata = 16'h0000;
    cpu_stall = 1'b0;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    if (!rst) begin
      if (w_fill_grant) begin
        mem_wen   = 1'b1;
        mem_waddr = r_addr;
        mem_wdata = r_value;
      end else if (cpu_wen) begin
        mem_wen   = 1'b1;
        mem_waddr = cpu_waddr;
        mem_wdata = cpu_wdata;
      end
      cpu_stall = w_fill_grant && cpu_wen;
      fill_busy = w_in_fill;
      fill_done = (r_state == StDone);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_addr       <= 16'h0000;
      r_remaining  <= 16'h0000;
      r_value      <= 16'h0000;
      r_starve_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_starve_cnt <= '0;
          if (fill_start) begin
            r_addr      <= fill_base;
            r_remaining <= fill_count;
            r_value     <= fill_value;
            r_state     <= (fill_count == 16'h0000) ? StDone : StFill;
          end
        end
        StFill: begin
          if (w_fill_grant) begin
            r_addr       <= r_addr + 16'h0001;
            r_remaining  <= r_remaining - 16'h0001;
            r_starve_cnt <= '0;
            if (r_remaining == 16'h0001) begin
              r_state <= StDone;
            end
          end else if (HasLimit) begin
            r_starve_cnt <= r_starve_cnt + CntW'(1);
          end
        end
        StDone: begin
          r_starve_cnt <= '0;
          r_state      <= StIdle;
        end
        default: begin
          r_starve_cnt <= '0;
          r_state      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: per-cycle vector table plus a write scoreboard for the
// starvation sequence and a hand-driven asynchronous reset mid-fill.
module tb_mem_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wen;
  logic [15:0] cpu_waddr;
  logic [15:0] cpu_wdata;
  logic        cpu_stall;
  logic        fill_start;
  logic [15:0] fill_base;
  logic [15:0] fill_count;
  logic [15:0] fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic        mem_wen;
  logic [15:0] mem_waddr;
  logic [15:0] mem_wdata;

  mem_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_wen    (cpu_wen),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_count (fill_count),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          seg;
    logic        cw;
    logic [15:0] ca;
    logic [15:0] cd;
    logic        fs;
    logic [15:0] fb;
    logic [15:0] fc;
    logic [15:0] fv;
    logic        e_wen;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    logic        e_stall;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int seg, input logic cw, input logic [15:0] ca,
                              input logic [15:0] cd, input logic fs, input logic [15:0] fb,
                              input logic [15:0] fc, input logic [15:0] fv, input logic ew,
                              input logic [15:0] ea, input logic [15:0] ed, input logic es,
                              input logic eb, input logic edn);
    vec_t v;
    v.seg = seg; v.cw = cw; v.ca = ca; v.cd = cd; v.fs = fs; v.fb = fb; v.fc = fc; v.fv = fv;
    v.e_wen = ew; v.e_addr = ea; v.e_data = ed; v.e_stall = es; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  task automatic run_seg(input int seg);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].seg == seg) begin
        @(posedge clk);
        #1;
        cpu_wen    = vecs[i].cw;
        cpu_waddr  = vecs[i].ca;
        cpu_wdata  = vecs[i].cd;
        fill_start = vecs[i].fs;
        fill_base  = vecs[i].fb;
        fill_count = vecs[i].fc;
        fill_value = vecs[i].fv;
        @(negedge clk);
        chk($sformatf("vec[%0d].wen", i), 16'(mem_wen), 16'(vecs[i].e_wen));
        if (vecs[i].e_wen) begin
          chk($sformatf("vec[%0d].addr", i), mem_waddr, vecs[i].e_addr);
          chk($sformatf("vec[%0d].data", i), mem_wdata, vecs[i].e_data);
        end
        chk($sformatf("vec[%0d].stall", i), 16'(cpu_stall), 16'(vecs[i].e_stall));
        chk($sformatf("vec[%0d].busy", i), 16'(fill_busy), 16'(vecs[i].e_busy));
        chk($sformatf("vec[%0d].done", i), 16'(fill_done), 16'(vecs[i].e_done));
      end
    end
  endtask

  // Scoreboard: fill writes live at 0x3xxx in the starvation sequence, CPU stores elsewhere.
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t  cpu_q[$];
  wr_t  fill_q[$];
  logic sb_on = 1'b0;

  always @(negedge clk) begin
    if (sb_on && mem_wen) begin
      wr_t w;
      if (mem_waddr[15:12] == 4'h3) begin
        if (fill_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb.fill_unexpected: got write %h=%h, expected none", mem_waddr,
                   mem_wdata);
        end else begin
          w = fill_q.pop_front();
          chk("sb.fill_addr", mem_waddr, w.addr);
          chk("sb.fill_data", mem_wdata, w.data);
        end
      end else begin
        if (cpu_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb.cpu_unexpected: got write %h=%h, expected none", mem_waddr,
                   mem_wdata);
        end else begin
          w = cpu_q.pop_front();
          chk("sb.cpu_addr", mem_waddr, w.addr);
          chk("sb.cpu_data", mem_wdata, w.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int idx;
    int pushed;

    // 1: fill E000..E003, no CPU traffic
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'hE000, 4, 16'h0041, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hE000, 16'h0041, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hE001, 16'h0041, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hE002, 16'h0041, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hE003, 16'h0041, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 2: zero count
    vecs.push_back(mk(2, 0, 0, 0, 1, 16'h1234, 0, 16'h0005, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 4: address wrap
    vecs.push_back(mk(4, 0, 0, 0, 1, 16'hFFFE, 3, 16'hAAAA, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFE, 16'hAAAA, 0, 1, 0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 16'hAAAA, 0, 1, 0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hAAAA, 0, 1, 0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // 5: interleave, fill_start ignored in FILL and DONE
    vecs.push_back(mk(5, 1, 16'h0100, 16'h1234, 1, 16'h0200, 3, 16'h5555,
                      1, 16'h0100, 16'h1234, 0, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0, 1, 16'h0300, 9, 16'h9999, 1, 16'h0200, 16'h5555, 0, 1, 0));
    vecs.push_back(mk(5, 1, 16'h0100, 16'h1234, 0, 0, 0, 0, 1, 16'h0100, 16'h1234, 0, 1, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0201, 16'h5555, 0, 1, 0));
    vecs.push_back(mk(5, 1, 16'h0100, 16'h1234, 0, 0, 0, 0, 1, 16'h0100, 16'h1234, 0, 1, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0202, 16'h5555, 0, 1, 0));
    vecs.push_back(mk(5, 1, 16'h0100, 16'h1234, 1, 16'h0400, 1, 16'h4444,
                      1, 16'h0100, 16'h1234, 0, 0, 1));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 6: after reset mid-fill, no done pulse, then a fresh fill
    vecs.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6, 0, 0, 0, 1, 16'h6000, 2, 16'h2222, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 16'h6000, 16'h2222, 0, 1, 0));
    vecs.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 16'h6001, 16'h2222, 0, 1, 0));
    vecs.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset with live-looking inputs: every output must still read 0.
    rst        = 1'b1;
    cpu_wen    = 1'b1;
    cpu_waddr  = 16'hABCD;
    cpu_wdata  = 16'h5A5A;
    fill_start = 1'b1;
    fill_base  = 16'h0010;
    fill_count = 16'h0004;
    fill_value = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wen", 16'(mem_wen), 16'h0);
    chk("rst.addr", mem_waddr, 16'h0);
    chk("rst.data", mem_wdata, 16'h0);
    chk("rst.stall", 16'(cpu_stall), 16'h0);
    chk("rst.busy", 16'(fill_busy), 16'h0);
    chk("rst.done", 16'(fill_done), 16'h0);
    rst        = 1'b0;
    cpu_wen    = 1'b0;
    fill_start = 1'b0;

    run_seg(1);
    run_seg(2);
    run_seg(4);
    run_seg(5);

    // 3: starvation with cpu_wen held high; stalled stores are re-presented.
    fill_q.push_back({16'h3000, 16'h7777});
    fill_q.push_back({16'h3001, 16'h7777});
    idx    = 0;
    pushed = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (idx != pushed) begin
        cpu_q.push_back({16'h0100 + 16'(idx), 16'hC000 + 16'(idx)});
        pushed = idx;
      end
      sb_on      = 1'b1;
      cpu_wen    = 1'b1;
      cpu_waddr  = 16'h0100 + 16'(idx);
      cpu_wdata  = 16'hC000 + 16'(idx);
      fill_start = (c == 0);
      fill_base  = 16'h3000;
      fill_count = 16'd2;
      fill_value = 16'h7777;
      @(negedge clk);
      chk($sformatf("starve[%0d].stall", c), 16'(cpu_stall), 16'(c == 5 || c == 10));
      chk($sformatf("starve[%0d].busy", c), 16'(fill_busy), 16'(c >= 1 && c <= 10));
      chk($sformatf("starve[%0d].done", c), 16'(fill_done), 16'(c == 11));
      if (!cpu_stall) idx++;
    end
    @(posedge clk);
    #1;
    cpu_wen    = 1'b0;
    fill_start = 1'b0;
    sb_on      = 1'b0;
    chk("starve.cpu_left", 16'(cpu_q.size()), 16'h0);
    chk("starve.fill_left", 16'(fill_q.size()), 16'h0);

    // 6: reset in FILL with remaining=5 drops mem_wen at once.
    @(posedge clk);
    #1;
    fill_start = 1'b1;
    fill_base  = 16'h5000;
    fill_count = 16'd8;
    fill_value = 16'h1111;
    repeat (4) begin
      @(posedge clk);
      #1;
      fill_start = 1'b0;
    end
    chk("rstfill.pre_wen", 16'(mem_wen), 16'h1);
    chk("rstfill.pre_addr", mem_waddr, 16'h5003);
    cpu_wen   = 1'b1;
    cpu_waddr = 16'h0777;
    rst       = 1'b1;
    #1;
    chk("rstfill.wen", 16'(mem_wen), 16'h0);
    chk("rstfill.busy", 16'(fill_busy), 16'h0);
    chk("rstfill.stall", 16'(cpu_stall), 16'h0);
    @(posedge clk);
    #1;
    cpu_wen = 1'b0;
    rst     = 1'b0;
    run_seg(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
